// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Shares one sequential radix-2 Booth multiplier among NREQ requesters.
//   A round-robin arbiter picks a requester, copies its operands into the
//   multiplier's mc/mp registers, pulses start, then waits a fixed number of
//   iterations. The product is captured on the one edge where it is known to
//   be valid and is returned to the owner as a one-cycle response.
//
// Ports
//   clk        rising-edge clock, shared with the multiplier
//   rst        synchronous active-high reset
//   req        per-requester request level
//   req_a      packed multiplicands, slice i = req_a[i*W +: W]
//   req_b      packed multiplier operands, slice i = req_b[i*W +: W]
//   gnt        one-hot grant pulse; operands are held in mul_mc/mul_mp from here on
//   rsp_valid  one-hot result pulse to the requester that was granted
//   rsp_prod   signed 2*W-bit product, valid with rsp_valid
//   rsp_err    multiplier never dropped busy; rsp_prod is forced to 0
//   mul_start  start strobe to the multiplier
//   mul_mc     registered multiplicand to the multiplier
//   mul_mp     registered multiplier operand to the multiplier
//   mul_prod   product from the multiplier
//   mul_busy   busy flag from the multiplier
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int ITER    = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [2*W-1:0]       rsp_prod,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [W-1:0]         mul_mc,
  output logic [W-1:0]         mul_mp,
  input  logic [2*W-1:0]       mul_prod,
  input  logic                 mul_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ITER + TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic            pick_valid;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] owner_oh;

  // Round-robin pick: scan offsets from the farthest back to ptr itself so the
  // last hit is the first set bit at or after ptr, wrapping around.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        pick = idx;
      end
    end
    pick_valid = |req;
    pick_oh    = NREQ'(1) << pick;
    owner_oh   = NREQ'(1) << owner;
  end

  // Main sequencer. Every output is a register written here so nothing
  // downstream sees a combinational path from req or the multiplier.
  // The product is taken on the first edge at or after ITER iterations where
  // busy is low; the multiplier keeps shifting afterwards, so a later edge
  // would sample a corrupted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_prod  <= '0;
      rsp_err   <= 1'b0;
      mul_start <= 1'b0;
      mul_mc    <= '0;
      mul_mp    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick;
            mul_mc    <= req_a[pick*W +: W];
            mul_mp    <= req_b[pick*W +: W];
            gnt       <= pick_oh;
            mul_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          gnt       <= '0;
          mul_start <= 1'b0;
          cnt       <= '0;
          state     <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if ((cnt >= CW'(ITER)) && !mul_busy) begin
            rsp_valid <= owner_oh;
            rsp_prod  <= mul_prod;
            rsp_err   <= 1'b0;
            state     <= DONE;
          end else if (cnt == CW'(ITER + TIMEOUT)) begin
            rsp_valid <= owner_oh;
            rsp_prod  <= '0;
            rsp_err   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= '0;
          rsp_prod  <= '0;
          rsp_err   <= 1'b0;
          // The requester just served drops to lowest priority.
          ptr       <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter
//   Directed bench for booth_mult_arbiter with a behavioural stand-in for the
//   sequential multiplier: it loads on start, raises busy for ITER edges,
//   presents the product for exactly one cycle, then keeps scrambling prod.
module tb_booth_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int ITER    = 8;
  localparam int TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*W-1:0]    req_a = '0;
  logic [NREQ*W-1:0]    req_b = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [2*W-1:0]       rsp_prod;
  logic                 rsp_err;
  logic                 mul_start;
  logic [W-1:0]         mul_mc;
  logic [W-1:0]         mul_mp;
  logic [2*W-1:0]       mul_prod;
  logic                 mul_busy;

  int checks   = 0;
  int failures = 0;

  booth_mult_arbiter #(
    .NREQ(NREQ), .W(W), .ITER(ITER), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
    .mul_prod(mul_prod), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in. stuck_busy makes it never release busy.
  logic               stuck_busy = 1'b0;
  int                 m_cnt      = 0;
  logic               m_busy     = 1'b0;
  logic [15:0]        m_prod     = 16'h0000;
  logic signed [15:0] m_res      = 16'sh0000;

  always @(posedge clk) begin
    if (mul_start === 1'b1) begin
      m_cnt  <= 0;
      m_busy <= 1'b1;
      m_prod <= 16'hBEEF;
      m_res  <= $signed({{8{mul_mc[7]}}, mul_mc}) * $signed({{8{mul_mp[7]}}, mul_mp});
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == ITER - 1) begin
        m_busy <= stuck_busy;
        m_prod <= m_res;
      end
    end else begin
      m_prod <= m_prod ^ 16'h5A5A;
    end
  end

  assign mul_prod = m_prod;
  assign mul_busy = m_busy;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one request mask to completion without judging the result.
  // gw/lat are -1 when the corresponding event never arrived.
  task automatic do_op(input logic [3:0] mask, output int gw, output logic [3:0] g,
                       output logic ms, output int lat, output logic [3:0] rv,
                       output logic [15:0] prod, output logic err);
    gw = -1; g = '0; ms = 1'b0; lat = -1; rv = '0; prod = 16'hFFFF; err = 1'bx;
    @(negedge clk);
    req = mask;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (gnt != 0) begin
        gw = k; g = gnt; ms = mul_start;
        break;
      end
    end
    req = '0;
    if (gw > 0) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (rsp_valid != 0) begin
          lat = k; rv = rsp_valid; prod = rsp_prod; err = rsp_err;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_err, mul_start} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {gnt, rsp_valid, rsp_err, mul_start});
    end
    checks++;
    if ({rsp_prod, mul_mc, mul_mp} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 0", {rsp_prod, mul_mc, mul_mp});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    int gw, lat; logic [3:0] g, rv; logic ms, err; logic [15:0] prod;
    req_a[0*W +: W] = 8'd7;
    req_b[0*W +: W] = 8'd6;
    do_op(4'b0001, gw, g, ms, lat, rv, prod, err);
    checks++;
    if (g !== 4'b0001 || gw !== 1 || ms !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_gnt: got gnt=%b wait=%0d start=%b expected 0001/1/1", g, gw, ms);
    end
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("[TB] FAIL single_latency: got %0d expected 10", lat);
    end
    checks++;
    if (rv !== 4'b0001 || prod !== 16'h002A || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_rsp: got %b/%h/%b expected 0001/002a/0", rv, prod, err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL single_pulse_width: got %b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_signed();
    int gw, lat; logic [3:0] g, rv; logic ms, err; logic [15:0] prod;
    req_a[2*W +: W] = 8'hFD;
    req_b[2*W +: W] = 8'h05;
    do_op(4'b0100, gw, g, ms, lat, rv, prod, err);
    checks++;
    if (rv !== 4'b0100 || prod !== 16'hFFF1 || lat !== 10) begin
      failures++;
      $display("[TB] FAIL signed_neg3x5: got %b/%h/lat%0d expected 0100/fff1/lat10", rv, prod, lat);
    end
    req_a[1*W +: W] = 8'h7F;
    req_b[1*W +: W] = 8'h80;
    do_op(4'b0010, gw, g, ms, lat, rv, prod, err);
    checks++;
    if (rv !== 4'b0010 || prod !== 16'hC080 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL signed_127xm128: got %b/%h/%b expected 0010/c080/0", rv, prod, err);
    end
  endtask

  task automatic test_round_robin();
    int gcyc[5]; int rcyc[5];
    logic [3:0] gv[5]; logic [3:0] rvv[5]; logic [15:0] rp[5];
    logic [3:0]  exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [15:0] exp_p[5] = '{16'h000A, 16'h0016, 16'h0024, 16'h0034, 16'h000A};
    int ng = 0;
    int nr = 0;
    for (int i = 0; i < 5; i++) begin
      gcyc[i] = 0; rcyc[i] = 0; gv[i] = '0; rvv[i] = '0; rp[i] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 8'(i + 1);
      req_b[i*W +: W] = 8'(i + 10);
    end
    req = 4'b1111;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (gnt != 0 && ng < 5) begin
        gcyc[ng] = k; gv[ng] = gnt; ng++;
      end
      if (rsp_valid != 0 && nr < 5) begin
        rcyc[nr] = k; rvv[nr] = rsp_valid; rp[nr] = rsp_prod; nr++;
      end
      if (nr == 5) break;
    end
    req = '0;
    checks++;
    if (ng !== 5 || nr !== 5) begin
      failures++;
      $display("[TB] FAIL rr_counts: got gnt=%0d rsp=%0d expected 5/5", ng, nr);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gv[i] !== exp_g[i] || rvv[i] !== exp_g[i]) begin
        failures++;
        $display("[TB] FAIL rr_order[%0d]: got gnt=%b rsp=%b expected %b", i, gv[i], rvv[i], exp_g[i]);
      end
      checks++;
      if (rp[i] !== exp_p[i] || rcyc[i] - gcyc[i] !== 10) begin
        failures++;
        $display("[TB] FAIL rr_result[%0d]: got %h lat%0d expected %h lat10", i, rp[i], rcyc[i] - gcyc[i], exp_p[i]);
      end
      if (i > 0) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] !== 12) begin
          failures++;
          $display("[TB] FAIL rr_spacing[%0d]: got %0d expected 12", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int gw, lat; logic [3:0] g, rv; logic ms, err; logic [15:0] prod;
    stuck_busy = 1'b1;
    req_a[0*W +: W] = 8'd5;
    req_b[0*W +: W] = 8'd5;
    do_op(4'b0001, gw, g, ms, lat, rv, prod, err);
    stuck_busy = 1'b0;
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("[TB] FAIL timeout_latency: got %0d expected 14", lat);
    end
    checks++;
    if (rv !== 4'b0001 || err !== 1'b1 || prod !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL timeout_rsp: got %b/%b/%h expected 0001/1/0000", rv, err, prod);
    end
    req_a[1*W +: W] = 8'd12;
    req_b[1*W +: W] = 8'hFF;
    do_op(4'b0010, gw, g, ms, lat, rv, prod, err);
    checks++;
    if (gw !== 1 || lat !== 10 || prod !== 16'hFFF4 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_recover: got wait%0d lat%0d %h/%b expected wait1 lat10 fff4/0", gw, lat, prod, err);
    end
  endtask

  task automatic test_reset_mid_op();
    int gw, lat; logic [3:0] g, rv; logic ms, err; logic [15:0] prod;
    logic saw_rsp = 1'b0;
    int wait_g = -1;
    req_a[2*W +: W] = 8'd9;
    req_b[2*W +: W] = 8'd9;
    @(negedge clk);
    req = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (gnt != 0) begin
        wait_g = k;
        break;
      end
    end
    req = '0;
    checks++;
    if (wait_g !== 1) begin
      failures++;
      $display("[TB] FAIL midop_gnt: got wait %0d expected 1", wait_g);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_err, mul_start, rsp_prod, mul_mc, mul_mp} !== '0) begin
      failures++;
      $display("[TB] FAIL midop_outputs: got %h expected 0",
               {gnt, rsp_valid, rsp_err, mul_start, rsp_prod, mul_mc, mul_mp});
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_no_rsp: got %b expected 0", saw_rsp);
    end
    req_a[1*W +: W] = 8'hFE;
    req_b[1*W +: W] = 8'd3;
    req_a[3*W +: W] = 8'd4;
    req_b[3*W +: W] = 8'd4;
    do_op(4'b1010, gw, g, ms, lat, rv, prod, err);
    checks++;
    if (g !== 4'b0010 || lat !== 10 || prod !== 16'hFFFA) begin
      failures++;
      $display("[TB] FAIL midop_next: got %b lat%0d %h expected 0010 lat10 fffa", g, lat, prod);
    end
  endtask

  task automatic test_withdraw();
    logic [3:0]  seen = '0;
    logic [3:0]  g1 = '0;
    logic [3:0]  g2 = '0;
    logic [15:0] p1 = 16'hFFFF;
    logic [15:0] p2 = 16'hFFFF;
    req_a[0*W +: W] = 8'hFF;
    req_b[0*W +: W] = 8'hFF;
    req_a[1*W +: W] = 8'd10;
    req_b[1*W +: W] = 8'd10;
    req_a[3*W +: W] = 8'd2;
    req_b[3*W +: W] = 8'd2;
    @(negedge clk);
    req = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      seen |= gnt;
      if (gnt != 0) begin
        g1 = gnt;
        break;
      end
    end
    req = '0;
    @(negedge clk);
    req = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      seen |= gnt;
      if (rsp_valid != 0) begin
        p1 = rsp_prod;
        break;
      end
    end
    checks++;
    if (g1 !== 4'b0010 || p1 !== 16'h0064) begin
      failures++;
      $display("[TB] FAIL withdraw_first: got %b/%h expected 0010/0064", g1, p1);
    end
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    g2 = gnt;
    seen |= gnt;
    req = '0;
    checks++;
    if (g2 !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL withdraw_winner: got %b expected 0001", g2);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      seen |= gnt;
      if (rsp_valid != 0) begin
        p2 = rsp_prod;
        break;
      end
    end
    repeat (15) begin
      @(negedge clk);
      seen |= gnt;
    end
    checks++;
    if (p2 !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL withdraw_prod: got %h expected 0001", p2);
    end
    checks++;
    if (seen[3] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL withdraw_no_gnt3: got %b expected 0", seen[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_signed();
    test_round_robin();
    test_timeout();
    test_reset_mid_op();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
